pipe_stage_reg: RTL
===================

// Module: pipe_stage_reg
// PURPOSE
//  Generic pipeline stage register that replaces the fixed per-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB).
//  Carries a control field and a data payload between stages, using a valid/ready handshake.
//  Optional 2-entry skid buffer gives a registered in_ready at full throughput.
//  Synchronous flush inserts a NOP bubble; a saturating counter records back-pressure stall cycles.
// PARAMETERS
//  CTRL_W      16  width of the control field; a flush forces it to all-zero (NOP)
//  DATA_W      32  width of the data payload (the stage packs pc, operands, imm, rd, etc.)
//  SKID         1  1 = 2-entry skid buffer with registered in_ready; 0 = single register, combinational in_ready
//  CLEAR_DATA   0  1 = flush and reset also zero the data registers; 0 = data registers hold their value
//  CNT_W       16  width of the stall counter
// PORTS
//  clk        in   1       clock
//  rst        in   1       synchronous reset, active-high
//  flush      in   1       synchronous flush: drop all held entries and present a bubble
//  in_valid   in   1       upstream entry valid
//  in_ready   out  1       this stage can accept an entry
//  in_ctrl    in   CTRL_W  upstream control field
//  in_data    in   DATA_W  upstream data payload
//  out_valid  out  1       output entry valid
//  out_ready  in   1       downstream accepts the output entry
//  out_ctrl   out  CTRL_W  control field presented to the next stage
//  out_data   out  DATA_W  data payload presented to the next stage
//  stall_cnt  out  CNT_W   saturating count of cycles with out_valid=1 and out_ready=0
// BEHAVIOUR
//  Transfers: accept = in_valid & in_ready; emit = out_valid & out_ready.
//  Reset (rst=1 at a clock edge) gives:
//   - out_valid=0, out_ctrl=0, out_data=0, stall_cnt=0, skid entry invalid;
//   - in_ready=1 (SKID=1), state EMPTY.
//  Latency: an entry accepted at edge N gives out_valid=1 after edge N, from a single register stage.
//  Throughput: one entry per cycle when out_ready stays at 1.
//  Stability: while out_valid=1 and out_ready=0, out_ctrl and out_data hold constant. Entries are never lost or duplicated.
//  SKID=0 (single register):
//   - in_ready = ~out_valid | out_ready, combinational.
//   - On accept: the register loads in_*. On emit with no accept: out_valid clears.
//  SKID=1: FSM states EMPTY, BUSY (main slot valid), FULL (main and skid slots valid).
//   - in_ready is a register, equal to (state != FULL).
//   - EMPTY: on accept, main loads in_* -> BUSY.
//   - BUSY, accept and out_ready=1: main loads in_*, stay BUSY.
//   - BUSY, accept and out_ready=0: skid loads in_* -> FULL.
//   - BUSY, no accept, out_ready=1 -> EMPTY. Otherwise hold.
//   - FULL, out_ready=1: main loads skid -> BUSY. Otherwise hold.
//   - out_* always come from the main slot.
//  Flush:
//   - Priority: rst > flush > handshake.
//   - Next state is EMPTY and out_valid=0. Ctrl of main and skid go to 0.
//   - Data registers go to 0 if CLEAR_DATA=1, otherwise they hold.
//   - An accept in the flush cycle is discarded. in_ready returns to 1 on the next cycle.
//   - flush and rst together behave as rst.
//  Stall counter:
//   - Increments when out_valid=1 and out_ready=0; saturates at all-ones.
//   - Cleared only by rst; flush does not clear it.
// STRUCTURE
//  Shared package pipe_pkg:
//   - FSM state encoding (EMPTY/BUSY/FULL);
//   - CTRL_NOP constant (all-zero);
//   - default CTRL_W/DATA_W for each stage.
//  Sub-module pipe_slot: a valid+ctrl+data register with load/clear. Instanced as the main slot, plus the skid slot when SKID=1.
//  FSM, in_ready register and stall counter live in the top module.
// TESTING
//  1. rst for 2 cycles, then release -> out_valid=0, out_ctrl=0, stall_cnt=0, in_ready=1.
//  2. Stream 0x1..0x8 with out_ready=1 -> out_data 0x1..0x8 on consecutive cycles, each one cycle after its accept.
//  3. SKID=1: accept 0xA, then hold out_ready=0 while sending 0xB -> FULL, in_ready=0, out_data stays 0xA;
//     then out_ready=1 -> 0xA then 0xB emitted, in_ready=1.
//  4. In FULL, assert flush with in_valid=1 carrying 0xC -> next cycle out_valid=0, out_ctrl=0, 0xC never emitted.
//  5. out_valid=1, out_ready=0 for 70000 cycles with CNT_W=16 -> stall_cnt saturates at 0xFFFF.
//  6. rst and flush together mid-stream with SKID=0 -> same state as test 1; combinational in_ready tracks out_ready.

Source files
------------

// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared types and constants for pipeline stage registers
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_BUSY  = 2'd1,
        ST_FULL  = 2'd2
    } stage_state_e;

    typedef enum logic [1:0] {
        STG_IF_ID  = 2'd0,
        STG_ID_EX  = 2'd1,
        STG_EX_MEM = 2'd2,
        STG_MEM_WB = 2'd3
    } stage_id_e;

    localparam int DEF_CTRL_W = 16;
    localparam int DEF_DATA_W = 32;

    localparam int CTRL_W_MAX = 64;
    localparam logic [CTRL_W_MAX-1:0] CTRL_NOP = '0;

    function automatic int stage_ctrl_w(stage_id_e stg);
        case (stg)
            STG_IF_ID:  return 8;
            STG_ID_EX:  return 16;
            STG_EX_MEM: return 12;
            default:    return 8;
        endcase
    endfunction

    // payloads: pc+instr, pc+rs1+rs2+imm+rd, alu+store+rd, result+rd
    function automatic int stage_data_w(stage_id_e stg);
        case (stg)
            STG_IF_ID:  return 64;
            STG_ID_EX:  return 133;
            STG_EX_MEM: return 69;
            default:    return 37;
        endcase
    endfunction

    function automatic logic ready_for_state(stage_state_e st);
        return st != ST_FULL;
    endfunction

endpackage

// File: rtl/pipe_stage_reg_if.sv
// rtl/pipe_stage_reg_if.sv - upstream/downstream handshake bundle of a stage register
interface pipe_stage_reg_if #(
    parameter int CTRL_W = 16,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
);
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [CTRL_W-1:0] in_ctrl;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [CTRL_W-1:0] out_ctrl;
    logic [DATA_W-1:0] out_data;
    logic [CNT_W-1:0]  stall_cnt;

    modport master (
        output flush, in_valid, in_ctrl, in_data, out_ready,
        input  in_ready, out_valid, out_ctrl, out_data, stall_cnt
    );

    modport slave (
        input  flush, in_valid, in_ctrl, in_data, out_ready,
        output in_ready, out_valid, out_ctrl, out_data, stall_cnt
    );
endinterface

// File: rtl/pipe_slot.sv
// rtl/pipe_slot.sv - one valid+ctrl+data holding register with load and clear
module pipe_slot
    import pipe_pkg::*;
#(
    parameter int CTRL_W     = 16,
    parameter int DATA_W     = 32,
    parameter bit CLEAR_DATA = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              load,
    input  logic              valid_nxt,
    input  logic [CTRL_W-1:0] ld_ctrl,
    input  logic [DATA_W-1:0] ld_data,
    output logic              valid,
    output logic [CTRL_W-1:0] ctrl,
    output logic [DATA_W-1:0] data
);
    logic              valid_q, valid_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic [DATA_W-1:0] data_q, data_d;

    // clear wins over load so an entry arriving in a flush cycle is dropped
    always_comb begin
        valid_d = valid_q;
        ctrl_d  = ctrl_q;
        data_d  = data_q;
        if (clear) begin
            valid_d = 1'b0;
            ctrl_d  = CTRL_W'(CTRL_NOP);
            if (CLEAR_DATA) data_d = '0;
        end else begin
            valid_d = valid_nxt;
            if (load) begin
                ctrl_d = ld_ctrl;
                data_d = ld_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            ctrl_q  <= ctrl_d;
            data_q  <= data_d;
        end
    end

    assign valid = valid_q;
    assign ctrl  = ctrl_q;
    assign data  = data_q;
endmodule

// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - generic valid/ready pipeline stage with optional skid slot,
// flush-to-NOP and saturating back-pressure counter
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int CTRL_W     = DEF_CTRL_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter bit SKID       = 1'b1,
    parameter bit CLEAR_DATA = 1'b0,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    pipe_stage_reg_if.slave  bus
);
    stage_state_e      state_q, state_d;
    logic              in_ready_q, in_ready_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

    logic              in_ready_w, accept, emit;
    logic              main_valid, main_load, main_sel_skid, main_valid_nxt;
    logic [CTRL_W-1:0] main_ctrl, main_ld_ctrl;
    logic [DATA_W-1:0] main_data, main_ld_data;
    logic              skid_valid, skid_load, skid_valid_nxt;
    logic [CTRL_W-1:0] skid_ctrl;
    logic [DATA_W-1:0] skid_data;

    assign in_ready_w = SKID ? in_ready_q : (~main_valid | bus.out_ready);
    assign accept     = bus.in_valid & in_ready_w;
    assign emit       = main_valid & bus.out_ready;

    always_comb begin
        state_d        = state_q;
        main_load      = 1'b0;
        main_sel_skid  = 1'b0;
        main_valid_nxt = main_valid;
        skid_load      = 1'b0;
        skid_valid_nxt = skid_valid;
        if (!SKID) begin
            if (accept) begin
                main_load      = 1'b1;
                main_valid_nxt = 1'b1;
            end else if (emit) begin
                main_valid_nxt = 1'b0;
            end
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        main_load      = 1'b1;
                        main_valid_nxt = 1'b1;
                        state_d        = ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (accept && bus.out_ready) begin
                        main_load = 1'b1;
                    end else if (accept) begin
                        skid_load      = 1'b1;
                        skid_valid_nxt = 1'b1;
                        state_d        = ST_FULL;
                    end else if (bus.out_ready) begin
                        main_valid_nxt = 1'b0;
                        state_d        = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (bus.out_ready) begin
                        main_load      = 1'b1;
                        main_sel_skid  = 1'b1;
                        skid_valid_nxt = 1'b0;
                        state_d        = ST_BUSY;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
        if (bus.flush) state_d = ST_EMPTY;
    end

    // registered ready looks one state ahead so it is valid on the cycle it is used
    always_comb begin
        in_ready_d  = ready_for_state(state_d);
        stall_cnt_d = stall_cnt_q;
        if (main_valid && !bus.out_ready && !(&stall_cnt_q))
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_EMPTY;
            in_ready_q  <= 1'b1;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign main_ld_ctrl = main_sel_skid ? skid_ctrl : bus.in_ctrl;
    assign main_ld_data = main_sel_skid ? skid_data : bus.in_data;

    pipe_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .CLEAR_DATA(CLEAR_DATA)) u_main (
        .clk       (clk),
        .rst       (rst),
        .clear     (bus.flush),
        .load      (main_load),
        .valid_nxt (main_valid_nxt),
        .ld_ctrl   (main_ld_ctrl),
        .ld_data   (main_ld_data),
        .valid     (main_valid),
        .ctrl      (main_ctrl),
        .data      (main_data)
    );

    generate
        if (SKID) begin : g_skid
            pipe_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .CLEAR_DATA(CLEAR_DATA)) u_skid (
                .clk       (clk),
                .rst       (rst),
                .clear     (bus.flush),
                .load      (skid_load),
                .valid_nxt (skid_valid_nxt),
                .ld_ctrl   (bus.in_ctrl),
                .ld_data   (bus.in_data),
                .valid     (skid_valid),
                .ctrl      (skid_ctrl),
                .data      (skid_data)
            );
        end else begin : g_no_skid
            assign skid_valid = 1'b0;
            assign skid_ctrl  = '0;
            assign skid_data  = '0;
        end
    endgenerate

    assign bus.in_ready  = in_ready_w;
    assign bus.out_valid = main_valid;
    assign bus.out_ctrl  = main_ctrl;
    assign bus.out_data  = main_data;
    assign bus.stall_cnt = stall_cnt_q;
endmodule
